bar_scan: RTL and testbench
===========================

BAR_SCAN -- requirements
Module: bar_scan

Interface
REQ-001 Parameter ROW1, default 10'd2: first scan row (y_in value).
REQ-002 Parameter ROW2, default 10'd7: second scan row.
REQ-003 Parameter ROW3, default 10'd12: third scan row.
REQ-004 Parameter MIN_EDGES, default 8'd8: minimum edge count for a valid row.
REQ-005 Parameter MAX_EDGES, default 8'd200: maximum edge count for a valid row.
REQ-006 clk  input  1  single system clock, one pixel per cycle.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 x_in  input  10  pixel column of the current stream pixel.
REQ-009 y_in  input  10  pixel row of the current stream pixel.
REQ-010 in_de  input  1  data enable; pixel valid when 1.
REQ-011 in_vs  input  1  vertical sync, active-high; its rising edge marks the frame boundary.
REQ-012 in_data  input  1  barcode pixel; 1 = bar (black), 0 = space.
REQ-013 scan_en  output  1  barcode recognised in the last complete frame; drives the display overlay colour.
REQ-014 edge_cnt  output  8  edge count of ROW1 latched at the last frame evaluation.
REQ-015 frame_done  output  1  one-cycle pulse at each frame evaluation.

Function
REQ-016 Block SHALL register in_vs once and detect its rising edge as vs_rise (one cycle after in_vs rises).
REQ-017 FSM states SHALL be WAIT_SYNC, IDLE, SCAN and EVAL.
REQ-018 WAIT_SYNC SHALL ignore all pixels and SHALL go to IDLE on vs_rise without evaluating; no partial frame is ever evaluated.
REQ-019 IDLE SHALL go to SCAN when in_de=1 and y_in equals ROW1, ROW2 or ROW3, recording the row index k (1..3).
REQ-020 On the first SCAN pixel, prev_pix SHALL load in_data and no edge SHALL be counted.
REQ-021 On each subsequent SCAN pixel with in_de=1, the row counter SHALL increment when in_data != prev_pix; the counter SHALL saturate at 8'hFF.
REQ-022 SCAN SHALL end when in_de falls: the counter is stored to cnt[k], valid[k] is set, and the FSM returns to IDLE.
REQ-023 vs_rise during SCAN SHALL discard the truncated row (valid[k] stays 0) and go to EVAL.
REQ-024 vs_rise in IDLE SHALL go to EVAL.
REQ-025 EVAL SHALL last exactly one cycle, pulse frame_done, and return to IDLE.
REQ-026 In EVAL, scan_en SHALL be set to 1 only if valid[1..3] are all 1, cnt[1]==cnt[2]==cnt[3], and MIN_EDGES <= cnt[1] <= MAX_EDGES; otherwise scan_en SHALL be set to 0.
REQ-027 In EVAL, edge_cnt SHALL load cnt[1], or 0 if valid[1]=0; valid[1..3] and cnt[1..3] SHALL clear.
REQ-028 scan_en and edge_cnt SHALL hold their value between evaluations; latency from in_vs rising to an updated scan_en is 2 cycles.
REQ-029 A scan row re-entered in the same frame SHALL overwrite its earlier cnt[k].
REQ-030 x_in SHALL be used only to detect a restart: x_in==0 while in SCAN SHALL close the current row (same as a de fall) before the new pixel is processed.

Reset
REQ-031 rst_n low SHALL immediately force: state WAIT_SYNC, scan_en=0, edge_cnt=0, frame_done=0, and all cnt/valid/prev_pix cleared.
REQ-032 Reset deassertion mid-frame SHALL resume in WAIT_SYNC; the first evaluation occurs at the second vs_rise after reset.

Structure
REQ-033 FSM state encoding and default row/threshold constants SHALL live in shared package bar_pkg, reused by the display stage.
REQ-034 The per-row edge counter with saturation SHALL be a sub-module, edge_count.

Verification
REQ-035 Reset, then 2 frames, each with rows 2/7/12 alternating 10 px bar/space over 480 px -> after the 2nd vs_rise: scan_en=1, edge_cnt=47, and frame_done pulses once.
REQ-036 Row 7 has 46 edges and rows 2/12 have 47 -> scan_en=0 and edge_cnt=47.
REQ-037 All rows solid white -> edge_cnt=0 and scan_en=0 (below MIN_EDGES).
REQ-038 Every pixel toggles (479 edges) -> counter saturates, edge_cnt=255, and scan_en=0 (above MAX_EDGES).
REQ-039 in_vs rises mid-row 12 -> valid[3]=0 and scan_en=0; the next full frame gives scan_en=1.
REQ-040 rst_n pulsed low during row 7 of a valid frame -> outputs are 0 immediately; no frame_done at the next vs_rise; the following frame gives scan_en=1.

Source files
------------

// File: rtl/bar_pkg.sv
// Shared definitions for the barcode row scanner and the display stage that
// consumes its result: FSM encoding, default scan rows and edge thresholds.
package bar_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    IDLE      = 2'd1,
    SCAN      = 2'd2,
    EVAL      = 2'd3
  } scan_state_e;

  localparam int         NUM_ROWS      = 3;
  localparam logic [9:0] ROW1_DEF      = 10'd2;
  localparam logic [9:0] ROW2_DEF      = 10'd7;
  localparam logic [9:0] ROW3_DEF      = 10'd12;
  localparam logic [7:0] MIN_EDGES_DEF = 8'd8;
  localparam logic [7:0] MAX_EDGES_DEF = 8'd200;
  localparam logic [7:0] CNT_MAX       = 8'hFF;

  typedef struct packed {
    logic       valid;
    logic [7:0] cnt;
  } row_rec_t;

  // Returns the 1-based scan row index for y, or 0 when y is not a scan row.
  function automatic logic [1:0] row_lookup(input logic [9:0] y,
                                            input logic [9:0] r1,
                                            input logic [9:0] r2,
                                            input logic [9:0] r3);
    if (y == r1) return 2'd1;
    if (y == r2) return 2'd2;
    if (y == r3) return 2'd3;
    return 2'd0;
  endfunction

endpackage

// File: rtl/bar_scan_edge_count.sv
// Running edge counter for the row currently being scanned; sticks at CNT_MAX.
module edge_count
  import bar_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                          cnt_d = 8'd0;
    else if (inc && cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bar_scan.sv
// Counts bar/space transitions on three fixed rows per frame and flags a
// barcode when all three rows agree and the count sits inside the window.
module bar_scan
  import bar_pkg::*;
#(
  parameter logic [9:0] ROW1      = ROW1_DEF,
  parameter logic [9:0] ROW2      = ROW2_DEF,
  parameter logic [9:0] ROW3      = ROW3_DEF,
  parameter logic [7:0] MIN_EDGES = MIN_EDGES_DEF,
  parameter logic [7:0] MAX_EDGES = MAX_EDGES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic       in_de,
  input  logic       in_vs,
  input  logic       in_data,
  output logic       scan_en,
  output logic [7:0] edge_cnt,
  output logic       frame_done
);

  scan_state_e             state_d, state_q;
  logic                    vs_q, vs_rise;
  logic [1:0]              k_d, k_q, hit, slot;
  logic                    prev_d, prev_q;
  row_rec_t [NUM_ROWS-1:0] rows_d, rows_q;
  logic                    scan_en_d, scan_en_q;
  logic                    frame_done_d, frame_done_q;
  logic [7:0]              edge_cnt_d, edge_cnt_q;
  logic [7:0]              run_cnt;
  logic                    cnt_clr, cnt_inc;
  logic [NUM_ROWS-1:0]     row_valid;
  logic                    cnt_eq, cnt_in_rng;

  assign vs_rise = in_vs & ~vs_q;
  assign hit     = row_lookup(y_in, ROW1, ROW2, ROW3);
  assign slot    = k_q - 2'd1;

  always_comb begin
    row_valid = '0;
    for (int i = 0; i < NUM_ROWS; i++) row_valid[i] = rows_q[i].valid;
  end

  assign cnt_eq     = (rows_q[0].cnt == rows_q[1].cnt) && (rows_q[1].cnt == rows_q[2].cnt);
  assign cnt_in_rng = (rows_q[0].cnt >= MIN_EDGES) && (rows_q[0].cnt <= MAX_EDGES);

  edge_count u_edge_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (run_cnt)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    prev_d       = prev_q;
    rows_d       = rows_q;
    scan_en_d    = scan_en_q;
    edge_cnt_d   = edge_cnt_q;
    frame_done_d = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      WAIT_SYNC: begin
        if (vs_rise) state_d = IDLE;
      end

      IDLE: begin
        if (vs_rise) begin
          state_d = EVAL;
        end else if (in_de && hit != 2'd0) begin
          state_d = SCAN;
          k_d     = hit;
          prev_d  = in_data;
          cnt_clr = 1'b1;
        end
      end

      SCAN: begin
        // A frame boundary mid-row drops the partial row entirely.
        if (vs_rise) begin
          state_d = EVAL;
        end else if (!in_de || x_in == 10'd0) begin
          rows_d[slot] = '{valid: 1'b1, cnt: run_cnt};
          state_d      = IDLE;
          // x wrapped with de still high: the current pixel may open a new row.
          if (in_de && hit != 2'd0) begin
            state_d = SCAN;
            k_d     = hit;
            prev_d  = in_data;
            cnt_clr = 1'b1;
          end
        end else begin
          cnt_inc = (in_data != prev_q);
          prev_d  = in_data;
        end
      end

      EVAL: begin
        frame_done_d = 1'b1;
        scan_en_d    = (&row_valid) && cnt_eq && cnt_in_rng;
        edge_cnt_d   = row_valid[0] ? rows_q[0].cnt : 8'd0;
        rows_d       = '0;
        state_d      = IDLE;
      end

      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_SYNC;
      vs_q         <= 1'b0;
      k_q          <= 2'd0;
      prev_q       <= 1'b0;
      rows_q       <= '0;
      scan_en_q    <= 1'b0;
      edge_cnt_q   <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= in_vs;
      k_q          <= k_d;
      prev_q       <= prev_d;
      rows_q       <= rows_d;
      scan_en_q    <= scan_en_d;
      edge_cnt_q   <= edge_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign scan_en    = scan_en_q;
  assign edge_cnt   = edge_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bar_scan.sv
// Frame-level bench for bar_scan: rows are built as 480-bit patterns and the
// expected result is derived by counting transitions in each pattern.
module tb_bar_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x_in = '0, y_in = '0;
  logic       in_de = 1'b0, in_vs = 1'b0, in_data = 1'b0;
  logic       scan_en, frame_done;
  logic [7:0] edge_cnt;

  bar_scan dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_in       (x_in),
    .y_in       (y_in),
    .in_de      (in_de),
    .in_vs      (in_vs),
    .in_data    (in_data),
    .scan_en    (scan_en),
    .edge_cnt   (edge_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int fd_cnt = 0;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  // reference model state
  bit         synced;
  logic       exp_se;
  logic [7:0] exp_ec;
  int         exp_fd;

  // observations from the last frame
  int         fd_seen;
  logic       lat_fd0, lat_fd1, lat_se;
  logic [7:0] lat_ec;
  logic       rst_se, rst_fd;
  logic [7:0] rst_ec;

  logic [479:0] alt10, alt46, white, toggle;

  function automatic logic [479:0] alt(input int first, input int run);
    logic [479:0] v;
    for (int i = 0; i < 480; i++) v[i] = (i < first) ? 1'b0 : (((i - first) / run) % 2 == 0);
    return v;
  endfunction

  function automatic logic [479:0] rand_row(input int maxrun);
    logic [479:0] v;
    logic b;
    int left;
    b = 1'($urandom);
    left = $urandom_range(1, maxrun);
    for (int i = 0; i < 480; i++) begin
      v[i] = b;
      left--;
      if (left == 0) begin
        b = ~b;
        left = $urandom_range(1, maxrun);
      end
    end
    return v;
  endfunction

  function automatic int edges(input logic [479:0] r);
    int n = 0;
    for (int i = 1; i < 480; i++) if (r[i] != r[i-1]) n++;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic de, input logic d);
    @(negedge clk);
    x_in = x; y_in = y; in_de = de; in_data = d;
  endtask

  task automatic blank(input int n);
    repeat (n) pix(10'd500, y_in, 1'b0, 1'b0);
  endtask

  // trunc>=0: vsync rises at that pixel of row 12. rst_pix>=0: reset pulse at
  // that pixel of row 7. dup: row 12 is first sent as pre3 and x wraps straight
  // into the real row 12 without a de gap.
  task automatic run_frame(input logic [479:0] r1, input logic [479:0] r2,
                           input logic [479:0] r3, input int trunc, input int rst_pix,
                           input bit dup, input logic [479:0] pre3);
    logic [479:0] r;
    int fd_start, e1, e2, e3;
    bit cut;
    fd_start = fd_cnt;
    cut = 0;
    for (int y = 0; y < 14 && !cut; y++) begin
      if (y == 2 || y == 7 || y == 12) begin
        r = (y == 2) ? r1 : (y == 7) ? r2 : r3;
        if (y == 12 && dup)
          for (int i = 0; i < 480; i++) pix(10'(i), 10'(y), 1'b1, pre3[i]);
        for (int i = 0; i < 480 && !cut; i++) begin
          if (y == 12 && i == trunc) cut = 1;
          else begin
            pix(10'(i), 10'(y), 1'b1, r[i]);
            if (y == 7 && i == rst_pix) begin
              #2 rst_n = 1'b0;
              #1 rst_se = scan_en; rst_ec = edge_cnt; rst_fd = frame_done;
              @(negedge clk);
              rst_n = 1'b1;
            end
          end
        end
      end else begin
        for (int i = 0; i < 16; i++) pix(10'(i), 10'(y), 1'b1, 1'($urandom));
      end
      if (!cut) blank(4);
    end
    @(negedge clk); in_vs = 1'b1;
    @(negedge clk); lat_fd0 = frame_done; in_de = 1'b0;
    @(negedge clk); lat_fd1 = frame_done; lat_se = scan_en; lat_ec = edge_cnt;
    repeat (2) @(negedge clk);
    in_vs = 1'b0;
    blank(4);
    fd_seen = fd_cnt - fd_start;

    if (rst_pix >= 0) begin
      exp_se = 1'b0; exp_ec = 8'd0; synced = 0;
    end
    if (!synced) begin
      exp_fd = 0;
      synced = 1;
    end else begin
      e1 = edges(r1); e2 = edges(r2); e3 = edges(r3);
      exp_fd = 1;
      exp_ec = 8'(e1);
      exp_se = (trunc < 0) && (e1 == e2) && (e2 == e3) && (e1 >= 8) && (e1 <= 200);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (scan_en !== 1'b0) begin errors++; $display("FAIL reset_scan_en: got %b want 0", scan_en); end
    if (edge_cnt !== 8'd0) begin errors++; $display("FAIL reset_edge_cnt: got %0d want 0", edge_cnt); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks += 2;
    if (scan_en !== 1'b0) begin errors++; $display("FAIL post_reset_scan_en: got %b want 0", scan_en); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL post_reset_frame_done: got %b want 0", frame_done); end
    synced = 0; exp_se = 1'b0; exp_ec = 8'd0;
  endtask

  task automatic test_basic();
    run_frame(alt10, alt10, alt10, -1, -1, 0, white);
    checks += 2;
    if (fd_seen !== exp_fd) begin errors++; $display("FAIL sync_frame_done: got %0d pulses want %0d", fd_seen, exp_fd); end
    if (lat_se !== exp_se) begin errors++; $display("FAIL sync_scan_en: got %b want %b", lat_se, exp_se); end
    run_frame(alt10, alt10, alt10, -1, -1, 0, white);
    checks += 5;
    if (lat_fd0 !== 1'b0) begin errors++; $display("FAIL basic_early_frame_done: got %b want 0", lat_fd0); end
    if (lat_fd1 !== 1'b1) begin errors++; $display("FAIL basic_latency_frame_done: got %b want 1", lat_fd1); end
    if (lat_se !== exp_se) begin errors++; $display("FAIL basic_scan_en: got %b want %b", lat_se, exp_se); end
    if (lat_ec !== exp_ec) begin errors++; $display("FAIL basic_edge_cnt: got %0d want %0d", lat_ec, exp_ec); end
    if (fd_seen !== exp_fd) begin errors++; $display("FAIL basic_frame_done_count: got %0d want %0d", fd_seen, exp_fd); end
    repeat (20) @(negedge clk);
    checks += 2;
    if (scan_en !== exp_se) begin errors++; $display("FAIL basic_hold_scan_en: got %b want %b", scan_en, exp_se); end
    if (edge_cnt !== exp_ec) begin errors++; $display("FAIL basic_hold_edge_cnt: got %0d want %0d", edge_cnt, exp_ec); end
  endtask

  task automatic test_mismatch();
    run_frame(alt10, alt46, alt10, -1, -1, 0, white);
    checks += 3;
    if (lat_se !== exp_se) begin errors++; $display("FAIL mismatch_scan_en: got %b want %b", lat_se, exp_se); end
    if (lat_ec !== exp_ec) begin errors++; $display("FAIL mismatch_edge_cnt: got %0d want %0d", lat_ec, exp_ec); end
    if (fd_seen !== exp_fd) begin errors++; $display("FAIL mismatch_frame_done: got %0d want %0d", fd_seen, exp_fd); end
  endtask

  task automatic test_white();
    run_frame(white, white, white, -1, -1, 0, white);
    checks += 2;
    if (lat_se !== exp_se) begin errors++; $display("FAIL white_scan_en: got %b want %b", lat_se, exp_se); end
    if (lat_ec !== exp_ec) begin errors++; $display("FAIL white_edge_cnt: got %0d want %0d", lat_ec, exp_ec); end
  endtask

  task automatic test_saturate();
    run_frame(toggle, toggle, toggle, -1, -1, 0, white);
    checks += 2;
    if (lat_se !== exp_se) begin errors++; $display("FAIL saturate_scan_en: got %b want %b", lat_se, exp_se); end
    if (lat_ec !== exp_ec) begin errors++; $display("FAIL saturate_edge_cnt: got %0d want %0d", lat_ec, exp_ec); end
  endtask

  task automatic test_truncate();
    run_frame(alt10, alt10, alt10, 200, -1, 0, white);
    checks += 3;
    if (lat_se !== exp_se) begin errors++; $display("FAIL trunc_scan_en: got %b want %b", lat_se, exp_se); end
    if (lat_ec !== exp_ec) begin errors++; $display("FAIL trunc_edge_cnt: got %0d want %0d", lat_ec, exp_ec); end
    if (fd_seen !== exp_fd) begin errors++; $display("FAIL trunc_frame_done: got %0d want %0d", fd_seen, exp_fd); end
    run_frame(alt10, alt10, alt10, -1, -1, 0, white);
    checks += 1;
    if (lat_se !== exp_se) begin errors++; $display("FAIL trunc_recover_scan_en: got %b want %b", lat_se, exp_se); end
  endtask

  task automatic test_reset_mid();
    run_frame(alt10, alt10, alt10, -1, 100, 0, white);
    checks += 6;
    if (rst_se !== 1'b0) begin errors++; $display("FAIL midreset_scan_en: got %b want 0", rst_se); end
    if (rst_ec !== 8'd0) begin errors++; $display("FAIL midreset_edge_cnt: got %0d want 0", rst_ec); end
    if (rst_fd !== 1'b0) begin errors++; $display("FAIL midreset_frame_done: got %b want 0", rst_fd); end
    if (fd_seen !== exp_fd) begin errors++; $display("FAIL midreset_no_eval: got %0d pulses want %0d", fd_seen, exp_fd); end
    if (lat_se !== exp_se) begin errors++; $display("FAIL midreset_hold_scan_en: got %b want %b", lat_se, exp_se); end
    if (lat_ec !== exp_ec) begin errors++; $display("FAIL midreset_hold_edge_cnt: got %0d want %0d", lat_ec, exp_ec); end
    run_frame(alt10, alt10, alt10, -1, -1, 0, white);
    checks += 3;
    if (lat_se !== exp_se) begin errors++; $display("FAIL midreset_next_scan_en: got %b want %b", lat_se, exp_se); end
    if (lat_ec !== exp_ec) begin errors++; $display("FAIL midreset_next_edge_cnt: got %0d want %0d", lat_ec, exp_ec); end
    if (fd_seen !== exp_fd) begin errors++; $display("FAIL midreset_next_frame_done: got %0d want %0d", fd_seen, exp_fd); end
  endtask

  task automatic test_restart();
    run_frame(alt10, alt10, alt10, -1, -1, 1, alt46);
    checks += 2;
    if (lat_se !== exp_se) begin errors++; $display("FAIL restart_scan_en: got %b want %b", lat_se, exp_se); end
    if (lat_ec !== exp_ec) begin errors++; $display("FAIL restart_edge_cnt: got %0d want %0d", lat_ec, exp_ec); end
  endtask

  task automatic test_random();
    logic [479:0] base, r2;
    int mode;
    for (int f = 0; f < 5; f++) begin
      mode = $urandom_range(0, 2);
      base = rand_row((mode == 2) ? 2 : 40);
      r2 = (mode == 1) ? rand_row(40) : base;
      run_frame(base, r2, base, -1, -1, 0, white);
      checks += 3;
      if (lat_se !== exp_se) begin errors++; $display("FAIL random%0d_scan_en: got %b want %b", f, lat_se, exp_se); end
      if (lat_ec !== exp_ec) begin errors++; $display("FAIL random%0d_edge_cnt: got %0d want %0d", f, lat_ec, exp_ec); end
      if (fd_seen !== exp_fd) begin errors++; $display("FAIL random%0d_frame_done: got %0d want %0d", f, fd_seen, exp_fd); end
    end
  endtask

  initial begin
    alt10  = alt(10, 10);
    alt46  = alt(20, 10);
    white  = '0;
    toggle = alt(1, 1);
    test_reset();
    test_basic();
    test_mismatch();
    test_white();
    test_saturate();
    test_truncate();
    test_reset_mid();
    test_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
